// File: rtl/apb_timer_slave.sv
// APB3/APB4 timer slave: prescaled 32-bit down-counter with reload, maskable
// interrupt, programmable wait states and PSLVERR on illegal accesses.
module apb_timer_slave #(
   parameter int WAIT_STATES = 1,
   parameter int PRESCALE    = 4,
   parameter int PRIV_WR     = 1
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        PCLKEN,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [15:0] PADDR,
   input  logic [31:0] PWDATA,
   input  logic [3:0]  PSTRB,
   input  logic [2:0]  PPROT,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic        TIMERINT
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [3:0]    wait_cnt_q, wait_cnt_d;
   logic [PW-1:0] pre_cnt_q, pre_cnt_d;
   logic [2:0]    ctrl_q, ctrl_d;
   logic [31:0]   value_q, value_d;
   logic [31:0]   reload_q, reload_d;
   logic          intstat_q, intstat_d;
   logic          timerint_q, timerint_d;

   logic [1:0]    off;
   logic          ready;
   logic          err;
   logic          wr;
   logic          tick;
   logic          pre_wrap;
   logic          hw_set;
   logic [31:0]   wmask;
   logic [31:0]   rd_mux;
   logic          unused_bits;

   assign unused_bits = ^{PADDR[1:0], PPROT[2:1]};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_mask
         assign wmask[gi*8 +: 8] = {8{PSTRB[gi]}};
      end
   endgenerate

   // Bus decode and response; a reset cycle never presents a response.
   always_comb begin
      off   = PADDR[3:2];
      ready = PSEL & PENABLE & (wait_cnt_q == 4'(WAIT_STATES)) & ~HRESET;
      err   = (PADDR[15:4] != 12'h000) |
              ((PRIV_WR != 0) & PWRITE & ~PPROT[0] & ((off == 2'd0) | (off == 2'd2)));
      wr    = ready & PCLKEN & PWRITE & ~err;

      case (off)
         2'd0:    rd_mux = {29'h0, ctrl_q};
         2'd1:    rd_mux = value_q;
         2'd2:    rd_mux = reload_q;
         default: rd_mux = {31'h0, intstat_q};
      endcase

      PREADY  = ready;
      PSLVERR = ready & err;
      PRDATA  = (ready & ~err) ? rd_mux : 32'h0;
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!PSEL) begin
         wait_cnt_d = 4'h0;
      end else if (PCLKEN && PENABLE) begin
         wait_cnt_d = ready ? 4'h0 : wait_cnt_q + 4'h1;
      end
   end

   // Counter datapath; bus writes are applied after the tick so they take priority.
   always_comb begin
      pre_wrap  = (pre_cnt_q == PW'(PRESCALE - 1));
      tick      = ctrl_q[0] & pre_wrap &
                  ~(wr & (off == 2'd0) & PSTRB[0] & ~PWDATA[0]);
      pre_cnt_d = (ctrl_q[0] && !pre_wrap) ? pre_cnt_q + PW'(1) : '0;
      hw_set    = tick & (value_q == 32'h0);

      ctrl_d    = ctrl_q;
      value_d   = value_q;
      reload_d  = reload_q;
      intstat_d = intstat_q;

      if (tick) begin
         if (value_q != 32'h0) begin
            value_d = value_q - 32'h1;
         end else if (ctrl_q[2]) begin
            value_d = reload_q;
         end else begin
            ctrl_d[0] = 1'b0;
         end
      end

      if (wr) begin
         case (off)
            2'd0: if (PSTRB[0]) ctrl_d = PWDATA[2:0];
            2'd1: value_d  = (value_q & ~wmask) | (PWDATA & wmask);
            2'd2: reload_d = (reload_q & ~wmask) | (PWDATA & wmask);
            default: if (PSTRB[0] && PWDATA[0]) intstat_d = 1'b0;
         endcase
      end

      if (hw_set) begin
         intstat_d = 1'b1;
      end

      timerint_d = intstat_q & ctrl_q[1];
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wait_cnt_q <= 4'h0;
         pre_cnt_q  <= '0;
         ctrl_q     <= 3'h0;
         value_q    <= 32'h0;
         reload_q   <= 32'h0;
         intstat_q  <= 1'b0;
         timerint_q <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         pre_cnt_q  <= pre_cnt_d;
         ctrl_q     <= ctrl_d;
         value_q    <= value_d;
         reload_q   <= reload_d;
         intstat_q  <= intstat_d;
         timerint_q <= timerint_d;
      end
   end

   assign TIMERINT = timerint_q;

endmodule
